// File: rtl/adc_cal_pkg.sv
// Shared constants and FSM encoding for the IDELAYE2 tap calibration block.
package adc_cal_pkg;

    localparam int unsigned TAP_W    = 5;
    localparam int unsigned NUM_TAPS = 32;
    localparam int unsigned RUN_W    = 6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        LOAD,
        SETTLE,
        CHECK,
        SEARCH,
        APPLY,
        DONE
    } cal_state_e;

endpackage

// File: rtl/idelay_tap_cal_if.sv
// Control/data bundle between the calibration controller, the delay lanes and the capture logic.
interface idelay_tap_cal_if
    import adc_cal_pkg::*;
#(
    parameter int unsigned LANES = 15
) ();

    logic                     idelay_rdy;
    logic                     cal_start;
    logic [LANES-1:0]         exp_pat;
    logic [LANES-1:0]         dat_in;
    logic                     dat_vld;
    logic [TAP_W*LANES-1:0]   cntvalue;
    logic [LANES-1:0]         ld;
    logic                     cal_busy;
    logic                     cal_done;
    logic [LANES-1:0]         cal_fail;

    modport master (
        output idelay_rdy, cal_start, exp_pat, dat_in, dat_vld,
        input  cntvalue, ld, cal_busy, cal_done, cal_fail
    );

    modport slave (
        input  idelay_rdy, cal_start, exp_pat, dat_in, dat_vld,
        output cntvalue, ld, cal_busy, cal_done, cal_fail
    );

endinterface

// File: rtl/idelay_win_search.sv
// Serial longest-run finder over a 32-tap pass map; one tap per cycle, done pulses after tap 31.
module idelay_win_search
    import adc_cal_pkg::*;
(
    input  logic                clk_del,
    input  logic                rst_del_n,
    input  logic                start_i,
    input  logic [NUM_TAPS-1:0] map_i,
    output logic [TAP_W-1:0]    centre_o,
    output logic [RUN_W-1:0]    len_o,
    output logic                done_o
);

    logic [NUM_TAPS-1:0] map_q, map_d;
    logic [TAP_W-1:0]    idx_q, idx_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [RUN_W-1:0]    len_q, len_d;
    logic [TAP_W-1:0]    centre_q, centre_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RUN_W-1:0]    run_inc;
    logic [RUN_W-1:0]    start_pos;

    always_comb begin
        map_d     = map_q;
        idx_d     = idx_q;
        run_d     = run_q;
        len_d     = len_q;
        centre_d  = centre_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        run_inc   = run_q + RUN_W'(1);
        start_pos = RUN_W'(idx_q) + RUN_W'(1) - run_inc;
        if (start_i) begin
            map_d    = map_i;
            idx_d    = '0;
            run_d    = '0;
            len_d    = '0;
            centre_d = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            if (map_q[idx_q]) begin
                run_d = run_inc;
                // Strictly longer only, so the earliest of equal-length runs is kept.
                if (run_inc > len_q) begin
                    len_d    = run_inc;
                    centre_d = TAP_W'(start_pos) + TAP_W'((run_inc - RUN_W'(1)) >> 1);
                end
            end else begin
                run_d = '0;
            end
            idx_d = idx_q + TAP_W'(1);
            if (idx_q == TAP_W'(NUM_TAPS - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_del or negedge rst_del_n) begin
        if (!rst_del_n) begin
            map_q    <= '0;
            idx_q    <= '0;
            run_q    <= '0;
            len_q    <= '0;
            centre_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            map_q    <= map_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            len_q    <= len_d;
            centre_q <= centre_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign centre_o = centre_q;
    assign len_o    = len_q;
    assign done_o   = done_q;

endmodule

// File: rtl/idelay_tap_cal.sv
// Sweeps all IDELAYE2 taps against a static ADC pattern and loads each lane's widest-window centre.
module idelay_tap_cal
    import adc_cal_pkg::*;
#(
    parameter int unsigned LANES       = 15,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned SAMPLES     = 64,
    parameter int unsigned MIN_WIN     = 4,
    parameter int unsigned DEFAULT_TAP = 0
) (
    input  logic            clk_del,
    input  logic            rst_del_n,
    idelay_tap_cal_if.slave cal_if
);

    localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int unsigned SMP_W  = $clog2(SAMPLES + 1);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [LANES-1:0][TAP_W-1:0]    lane_taps_t;
    typedef logic [LANES-1:0][NUM_TAPS-1:0] pass_map_t;

    cal_state_e        state_q, state_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [LANES-1:0]  fail_acc_q, fail_acc_d;
    pass_map_t         pass_map_q, pass_map_d;
    lane_taps_t        tap_res_q, tap_res_d;
    lane_taps_t        cntvalue_q, cntvalue_d;
    logic [LANES-1:0]  ld_q, ld_d;
    logic [LANES-1:0]  fail_q, fail_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              win_start_q, win_start_d;
    logic [LANES-1:0]  fail_now;
    logic [TAP_W-1:0]  win_centre;
    logic [RUN_W-1:0]  win_len;
    logic              win_done;

    idelay_win_search u_win_search (
        .clk_del   (clk_del),
        .rst_del_n (rst_del_n),
        .start_i   (win_start_q),
        .map_i     (pass_map_q[lane_q]),
        .centre_o  (win_centre),
        .len_o     (win_len),
        .done_o    (win_done)
    );

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        set_cnt_d   = set_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        lane_d      = lane_q;
        fail_acc_d  = fail_acc_q;
        pass_map_d  = pass_map_q;
        tap_res_d   = tap_res_q;
        cntvalue_d  = cntvalue_q;
        fail_d      = fail_q;
        done_d      = done_q;
        ld_d        = '0;
        win_start_d = 1'b0;
        fail_now    = fail_acc_q | (cal_if.dat_in ^ cal_if.exp_pat);

        unique case (state_q)
            IDLE: begin
                if (cal_if.cal_start) begin
                    state_d = WAIT_RDY;
                    done_d  = 1'b0;
                    fail_d  = '0;
                end
            end
            WAIT_RDY: begin
                if (cal_if.idelay_rdy) begin
                    tap_d      = '0;
                    cntvalue_d = '0;
                    ld_d       = '1;
                    state_d    = LOAD;
                end
            end
            LOAD, SETTLE, CHECK: begin
                // Losing IDELAYCTRL lock invalidates the sweep so far.
                if (!cal_if.idelay_rdy) begin
                    pass_map_d = '0;
                    state_d    = WAIT_RDY;
                end else if (state_q == LOAD) begin
                    set_cnt_d = '0;
                    state_d   = SETTLE;
                end else if (state_q == SETTLE) begin
                    if (set_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                        smp_cnt_d  = '0;
                        fail_acc_d = '0;
                        state_d    = CHECK;
                    end else begin
                        set_cnt_d = set_cnt_q + SET_W'(1);
                    end
                end else if (cal_if.dat_vld) begin
                    if (smp_cnt_q == SMP_W'(SAMPLES - 1)) begin
                        for (int unsigned i = 0; i < LANES; i++) begin
                            pass_map_d[i][tap_q] = ~fail_now[i];
                        end
                        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                            lane_d      = '0;
                            win_start_d = 1'b1;
                            state_d     = SEARCH;
                        end else begin
                            tap_d      = tap_q + TAP_W'(1);
                            cntvalue_d = {LANES{tap_d}};
                            ld_d       = '1;
                            state_d    = LOAD;
                        end
                    end else begin
                        smp_cnt_d  = smp_cnt_q + SMP_W'(1);
                        fail_acc_d = fail_now;
                    end
                end
            end
            SEARCH: begin
                if (win_done) begin
                    if (win_len >= RUN_W'(MIN_WIN)) begin
                        tap_res_d[lane_q] = win_centre;
                    end else begin
                        tap_res_d[lane_q] = TAP_W'(DEFAULT_TAP);
                        fail_d[lane_q]    = 1'b1;
                    end
                    if (lane_q == LANE_W'(LANES - 1)) begin
                        cntvalue_d = tap_res_d;
                        ld_d       = '1;
                        state_d    = APPLY;
                    end else begin
                        lane_d      = lane_q + LANE_W'(1);
                        win_start_d = 1'b1;
                    end
                end
            end
            APPLY: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk_del or negedge rst_del_n) begin
        if (!rst_del_n) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            set_cnt_q   <= '0;
            smp_cnt_q   <= '0;
            lane_q      <= '0;
            fail_acc_q  <= '0;
            pass_map_q  <= '0;
            tap_res_q   <= '0;
            cntvalue_q  <= '0;
            ld_q        <= '0;
            fail_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            win_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            set_cnt_q   <= set_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            lane_q      <= lane_d;
            fail_acc_q  <= fail_acc_d;
            pass_map_q  <= pass_map_d;
            tap_res_q   <= tap_res_d;
            cntvalue_q  <= cntvalue_d;
            ld_q        <= ld_d;
            fail_q      <= fail_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            win_start_q <= win_start_d;
        end
    end

    assign cal_if.cntvalue = cntvalue_q;
    assign cal_if.ld       = ld_q;
    assign cal_if.cal_busy = busy_q;
    assign cal_if.cal_done = done_q;
    assign cal_if.cal_fail = fail_q;

endmodule

// File: tb/tb_idelay_tap_cal.sv
// Bench for idelay_tap_cal: models the delay lanes per tap and checks results against a window model.
module tb_idelay_tap_cal;

    localparam int unsigned LANES       = 15;
    localparam int unsigned SETTLE_CYC  = 8;
    localparam int unsigned SAMPLES     = 64;
    localparam int unsigned MIN_WIN     = 4;
    localparam int unsigned DEFAULT_TAP = 0;
    localparam int unsigned LD_PER_RUN  = 33;
    localparam int unsigned LD_GAP      = 1 + SETTLE_CYC + SAMPLES;
    localparam int          BUDGET      = 20000;

    logic clk_del = 1'b0;
    logic rst_del_n;

    idelay_tap_cal_if #(.LANES(LANES)) bus ();

    idelay_tap_cal #(
        .LANES       (LANES),
        .SETTLE_CYC  (SETTLE_CYC),
        .SAMPLES     (SAMPLES),
        .MIN_WIN     (MIN_WIN),
        .DEFAULT_TAP (DEFAULT_TAP)
    ) dut (
        .clk_del   (clk_del),
        .rst_del_n (rst_del_n),
        .cal_if    (bus.slave)
    );

    always #5 clk_del = ~clk_del;

    int          n_checks;
    int          n_fails;
    logic [31:0] lane_pass [LANES] = '{default: 32'hFFFF_FFFF};
    logic [4:0]  delay_tap [LANES] = '{default: 5'd0};
    bit          vld_toggle = 1'b0;
    int unsigned cyc = 0;
    int unsigned ld_cnt = 0;
    int unsigned ld_cyc_q [$];

    // Delay-lane model: each lane latches its tap on ld; data matches exp_pat only at passing taps.
    initial begin
        bit ph;
        ph = 1'b0;
        forever begin
            @(negedge clk_del);
            cyc++;
            if (bus.ld[0] === 1'b1) begin
                ld_cnt++;
                ld_cyc_q.push_back(cyc);
            end
            ph = ~ph;
            bus.dat_vld = vld_toggle ? ph : 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (bus.ld[i] === 1'b1) delay_tap[i] = bus.cntvalue[5*i +: 5];
                if (!bus.dat_vld)
                    bus.dat_in[i] = ~bus.exp_pat[i];
                else if (lane_pass[i][delay_tap[i]])
                    bus.dat_in[i] = bus.exp_pat[i];
                else
                    bus.dat_in[i] = bus.exp_pat[i] ^ 1'($urandom_range(0, 1));
            end
        end
    end

    // Widest run of ones by exhaustive scan from every start tap; first start wins ties.
    function automatic void ref_window(input logic [31:0] m, output logic [4:0] tap, output bit fail);
        int best_len;
        int best_s;
        best_len = 0;
        best_s   = 0;
        for (int s = 0; s < 32; s++) begin
            int len;
            len = 0;
            while ((s + len) < 32 && m[s + len]) len++;
            if (len > best_len) begin
                best_len = len;
                best_s   = s;
            end
        end
        if (best_len < int'(MIN_WIN)) begin
            tap  = 5'(DEFAULT_TAP);
            fail = 1'b1;
        end else begin
            tap  = 5'(best_s + (best_len - 1) / 2);
            fail = 1'b0;
        end
    endfunction

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
        return m;
    endfunction

    task automatic pulse_start();
        @(negedge clk_del);
        bus.cal_start = 1'b1;
        @(negedge clk_del);
        bus.cal_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (bus.cal_done !== 1'b1 && n < BUDGET) begin
            @(negedge clk_del);
            n++;
        end
        n_checks++;
        if (bus.cal_done !== 1'b1) begin
            n_fails++;
            $display("FAIL %s done_timeout: cal_done=%b after %0d cycles, required 1", tag, bus.cal_done, n);
        end
    endtask

    task automatic wait_ld_tap(input int t, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_del);
            n++;
        end while (!(bus.ld[0] === 1'b1 && bus.cntvalue[4:0] == 5'(t)) && n < BUDGET);
        n_checks++;
        if (n >= BUDGET) begin
            n_fails++;
            $display("FAIL %s ld_tap%0d_timeout: no load of tap %0d seen within %0d cycles", tag, t, t, BUDGET);
        end
    endtask

    task automatic check_result(input string tag, input int unsigned ld0, input int unsigned exp_ld);
        logic [4:0]             et;
        bit                     ef;
        logic [LANES-1:0]       efail;
        logic [5*LANES-1:0]     exp_cv;
        for (int i = 0; i < LANES; i++) begin
            ref_window(lane_pass[i], et, ef);
            efail[i]         = ef;
            exp_cv[5*i +: 5] = et;
            n_checks++;
            if (bus.cntvalue[5*i +: 5] !== et) begin
                n_fails++;
                $display("FAIL %s lane%0d_tap: got %0d, required %0d", tag, i, bus.cntvalue[5*i +: 5], et);
            end
        end
        n_checks++;
        if (bus.cal_fail !== efail) begin
            n_fails++;
            $display("FAIL %s cal_fail: got %h, required %h", tag, bus.cal_fail, efail);
        end
        n_checks++;
        if (bus.cal_busy !== 1'b0) begin
            n_fails++;
            $display("FAIL %s busy_at_done: got %b, required 0", tag, bus.cal_busy);
        end
        n_checks++;
        if (ld_cnt - ld0 !== exp_ld) begin
            n_fails++;
            $display("FAIL %s ld_pulses: got %0d, required %0d", tag, ld_cnt - ld0, exp_ld);
        end
        repeat (6) @(negedge clk_del);
        n_checks++;
        if (bus.cntvalue !== exp_cv || bus.cal_done !== 1'b1 || bus.ld !== '0) begin
            n_fails++;
            $display("FAIL %s hold_after_done: cntvalue=%h done=%b ld=%h, required %h 1 0",
                     tag, bus.cntvalue, bus.cal_done, bus.ld, exp_cv);
        end
    endtask

    task automatic run_cal(input string tag, input int unsigned exp_ld);
        int unsigned ld0;
        ld0 = ld_cnt;
        pulse_start();
        n_checks++;
        if (bus.cal_busy !== 1'b1 || bus.cal_done !== 1'b0) begin
            n_fails++;
            $display("FAIL %s start_flags: busy=%b done=%b, required 1 0", tag, bus.cal_busy, bus.cal_done);
        end
        wait_done(tag);
        check_result(tag, ld0, exp_ld);
    endtask

    task automatic randomize_maps();
        for (int i = 0; i < LANES; i++) begin
            int lo;
            int hi;
            lo = $urandom_range(0, 31);
            hi = $urandom_range(lo, 31);
            case ($urandom_range(0, 3))
                0:       lane_pass[i] = $urandom;
                1:       lane_pass[i] = span(lo, hi);
                2:       lane_pass[i] = span(lo, hi) | span($urandom_range(0, 31), $urandom_range(0, 31));
                default: lane_pass[i] = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
        end
        bus.exp_pat = LANES'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_del);
        n_checks++;
        if (bus.cntvalue !== '0 || bus.ld !== '0 || bus.cal_busy !== 1'b0 ||
            bus.cal_done !== 1'b0 || bus.cal_fail !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: cv=%h ld=%h busy=%b done=%b fail=%h, required all 0",
                     bus.cntvalue, bus.ld, bus.cal_busy, bus.cal_done, bus.cal_fail);
        end
        rst_del_n = 1'b1;
        repeat (10) @(negedge clk_del);
        n_checks++;
        if (bus.cal_busy !== 1'b0 || ld_cnt !== 0) begin
            n_fails++;
            $display("FAIL reset_idle: busy=%b ld_pulses=%0d, required 0 0", bus.cal_busy, ld_cnt);
        end
    endtask

    task automatic test_basic();
        int unsigned ld0;
        int unsigned gap;
        foreach (lane_pass[i]) lane_pass[i] = 32'hFFFF_FFFF;
        lane_pass[3] = span(8, 20);
        bus.exp_pat  = LANES'($urandom);
        ld0 = ld_cnt;
        run_cal("basic", LD_PER_RUN);
        gap = ld_cyc_q[ld0 + 2] - ld_cyc_q[ld0 + 1];
        n_checks++;
        if (gap !== LD_GAP) begin
            n_fails++;
            $display("FAIL basic tap_period: got %0d cycles, required %0d", gap, LD_GAP);
        end
    endtask

    task automatic test_windows();
        foreach (lane_pass[i]) lane_pass[i] = 32'hFFFF_FFFF;
        lane_pass[0] = span(2, 5) | span(10, 25);
        lane_pass[1] = span(0, 4) | span(20, 24);
        lane_pass[2] = span(0, 31) & ~span(16, 16);
        lane_pass[4] = span(28, 31);
        bus.exp_pat  = LANES'($urandom);
        run_cal("windows", LD_PER_RUN);
    endtask

    task automatic test_fail_lanes();
        foreach (lane_pass[i]) lane_pass[i] = 32'hFFFF_FFFF;
        lane_pass[5]  = 32'h0;
        lane_pass[6]  = span(29, 31);
        lane_pass[14] = span(0, 3);
        bus.exp_pat   = LANES'($urandom);
        run_cal("fail_lanes", LD_PER_RUN);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            randomize_maps();
            run_cal($sformatf("random%0d", r), LD_PER_RUN);
        end
    endtask

    task automatic test_rdy();
        int unsigned ld0;
        randomize_maps();
        bus.idelay_rdy = 1'b0;
        ld0 = ld_cnt;
        pulse_start();
        repeat (100) @(negedge clk_del);
        n_checks++;
        if (ld_cnt !== ld0 || bus.cal_busy !== 1'b1) begin
            n_fails++;
            $display("FAIL rdy wait_no_load: ld_pulses=%0d busy=%b, required 0 1", ld_cnt - ld0, bus.cal_busy);
        end
        bus.idelay_rdy = 1'b1;
        n_checks++;
        if (bus.ld !== '0) begin
            n_fails++;
            $display("FAIL rdy ld_early: got %h, required 0", bus.ld);
        end
        @(negedge clk_del);
        n_checks++;
        if (bus.ld !== '1 || bus.cntvalue !== '0) begin
            n_fails++;
            $display("FAIL rdy first_ld: ld=%h cv=%h, required all-ones and 0", bus.ld, bus.cntvalue);
        end
        wait_ld_tap(12, "rdy");
        @(negedge clk_del);
        bus.idelay_rdy = 1'b0;
        repeat (20) @(negedge clk_del);
        bus.idelay_rdy = 1'b1;
        wait_done("rdy");
        check_result("rdy", ld0, 13 + LD_PER_RUN);
    endtask

    task automatic test_busy_start();
        int unsigned ld0;
        randomize_maps();
        ld0 = ld_cnt;
        pulse_start();
        wait_ld_tap(7, "busy_start");
        pulse_start();
        wait_done("busy_start");
        check_result("busy_start", ld0, LD_PER_RUN);
    endtask

    task automatic test_vld_toggle();
        int unsigned ld0;
        int unsigned gap;
        randomize_maps();
        vld_toggle = 1'b1;
        ld0 = ld_cnt;
        run_cal("vld_toggle", LD_PER_RUN);
        vld_toggle = 1'b0;
        gap = ld_cyc_q[ld0 + 2] - ld_cyc_q[ld0 + 1];
        n_checks++;
        if (gap < 1 + SETTLE_CYC + 2 * SAMPLES - 1 || gap > 1 + SETTLE_CYC + 2 * SAMPLES) begin
            n_fails++;
            $display("FAIL vld_toggle tap_period: got %0d cycles, required %0d or %0d",
                     gap, 1 + SETTLE_CYC + 2 * SAMPLES - 1, 1 + SETTLE_CYC + 2 * SAMPLES);
        end
    endtask

    task automatic test_async_reset();
        int unsigned ld0;
        randomize_maps();
        pulse_start();
        wait_ld_tap(3, "async_reset");
        repeat (30) @(negedge clk_del);
        n_checks++;
        if (bus.cal_busy !== 1'b1 || bus.cntvalue[4:0] !== 5'd3) begin
            n_fails++;
            $display("FAIL async_reset pre_state: busy=%b tap=%0d, required 1 3", bus.cal_busy, bus.cntvalue[4:0]);
        end
        #1 rst_del_n = 1'b0;
        #1;
        n_checks++;
        if (bus.cntvalue !== '0 || bus.ld !== '0 || bus.cal_busy !== 1'b0 ||
            bus.cal_done !== 1'b0 || bus.cal_fail !== '0) begin
            n_fails++;
            $display("FAIL async_reset outputs: cv=%h ld=%h busy=%b done=%b fail=%h, required all 0",
                     bus.cntvalue, bus.ld, bus.cal_busy, bus.cal_done, bus.cal_fail);
        end
        @(negedge clk_del);
        rst_del_n = 1'b1;
        ld0 = ld_cnt;
        repeat (50) @(negedge clk_del);
        n_checks++;
        if (bus.cal_busy !== 1'b0 || bus.cal_done !== 1'b0 || ld_cnt !== ld0) begin
            n_fails++;
            $display("FAIL async_reset idle: busy=%b done=%b ld_pulses=%0d, required 0 0 0",
                     bus.cal_busy, bus.cal_done, ld_cnt - ld0);
        end
        randomize_maps();
        run_cal("after_reset", LD_PER_RUN);
    endtask

    initial begin
        n_checks       = 0;
        n_fails        = 0;
        rst_del_n      = 1'b1;
        bus.cal_start  = 1'b0;
        bus.idelay_rdy = 1'b1;
        bus.exp_pat    = '0;
        #2 rst_del_n   = 1'b0;
        test_reset();
        test_basic();
        test_windows();
        test_fail_lanes();
        test_random();
        test_rdy();
        test_busy_start();
        test_vld_toggle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
